// File: rtl/shift_register.sv
// Serial-peripheral data path: right-shifting register with parallel load.
// New bits enter at the MSB and leave from the LSB; the whole word is visible in parallel.
module shift_register #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             peripheralClkEdge,
    input  logic             parallelLoad,
    input  logic [width-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic [width-1:0] parallelDataOut,
    output logic             serialDataOut
);

    logic [width-1:0] mem_q;
    logic [width-1:0] mem_d;

    // A load that coincides with a strobe wins, and that strobe is dropped.
    always_comb begin
        mem_d = mem_q;
        if (parallelLoad) begin
            mem_d = parallelDataIn;
        end else if (peripheralClkEdge) begin
            mem_d = {serialDataIn, mem_q[width-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign parallelDataOut = mem_q;
    assign serialDataOut   = mem_q[0];

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register: reset, load, shift, fill, priority and mid-shift reset.
module tb_shift_register;

    logic       clk;
    logic       reset_n;
    logic       peripheralClkEdge;
    logic       parallelLoad;
    logic [7:0] parallelDataIn;
    logic       serialDataIn;
    logic [7:0] parallelDataOut;
    logic       serialDataOut;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q;
    logic [7:0] fill_bits;

    shift_register #(.width(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .peripheralClkEdge(peripheralClkEdge),
        .parallelLoad     (parallelLoad),
        .parallelDataIn   (parallelDataIn),
        .serialDataIn     (serialDataIn),
        .parallelDataOut  (parallelDataOut),
        .serialDataOut    (serialDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        peripheralClkEdge = 1'b0;
        parallelLoad      = 1'b0;
        parallelDataIn    = 8'h00;
        serialDataIn      = 1'b0;
        tick();

        // Arbitrary activity, then reset.
        reset_n        = 1'b1;
        parallelLoad   = 1'b1;
        parallelDataIn = 8'h5A;
        tick();
        check("pre_reset_load", parallelDataOut, 8'h5A);
        parallelLoad = 1'b0;
        reset_n      = 1'b0;
        tick();
        check("reset_pdo", parallelDataOut, 8'h00);
        check("reset_sdo", {7'd0, serialDataOut}, 8'h00);

        // Reset overrides load.
        parallelLoad   = 1'b1;
        parallelDataIn = 8'hFF;
        tick();
        check("reset_over_load", parallelDataOut, 8'h00);

        // Parallel load.
        reset_n        = 1'b1;
        parallelDataIn = 8'hA5;
        tick();
        parallelLoad = 1'b0;
        check("load_pdo", parallelDataOut, 8'hA5);
        check("load_sdo", {7'd0, serialDataOut}, 8'h01);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("load_hold", parallelDataOut, 8'hA5);
        end

        // Single shifts.
        serialDataIn      = 1'b1;
        peripheralClkEdge = 1'b1;
        tick();
        peripheralClkEdge = 1'b0;
        check("shift1_pdo", parallelDataOut, 8'hD2);
        check("shift1_sdo", {7'd0, serialDataOut}, 8'h00);
        serialDataIn      = 1'b0;
        peripheralClkEdge = 1'b1;
        tick();
        peripheralClkEdge = 1'b0;
        check("shift2_pdo", parallelDataOut, 8'h69);
        check("shift2_sdo", {7'd0, serialDataOut}, 8'h01);

        // Serial fill from zero: 1,0,1,0,1,0,1,0 with strobes 10 clks apart.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("fill_start", parallelDataOut, 8'h00);
        exp_q     = 8'h00;
        fill_bits = 8'b0101_0101;
        for (int i = 0; i < 8; i++) begin
            serialDataIn      = fill_bits[i];
            peripheralClkEdge = 1'b1;
            tick();
            peripheralClkEdge = 1'b0;
            exp_q = {fill_bits[i], exp_q[7:1]};
            check("fill_step", parallelDataOut, exp_q);
            for (int j = 0; j < 9; j++) begin
                tick();
                check("fill_idle", parallelDataOut, exp_q);
            end
        end
        check("fill_final_pdo", parallelDataOut, 8'h55);
        check("fill_final_sdo", {7'd0, serialDataOut}, 8'h01);

        // Priority: load beats a simultaneous strobe.
        parallelLoad   = 1'b1;
        parallelDataIn = 8'h3C;
        tick();
        check("prio_preload", parallelDataOut, 8'h3C);
        parallelDataIn    = 8'h81;
        peripheralClkEdge = 1'b1;
        serialDataIn      = 1'b1;
        tick();
        parallelLoad = 1'b0;
        check("prio_load_wins", parallelDataOut, 8'h81);
        serialDataIn = 1'b0;
        tick();
        tick();
        tick();
        peripheralClkEdge = 1'b0;
        check("held_strobe_pdo", parallelDataOut, 8'h10);
        check("held_strobe_sdo", {7'd0, serialDataOut}, 8'h00);
        tick();
        check("held_strobe_after", parallelDataOut, 8'h10);

        // Reset in the middle of shifting.
        parallelLoad   = 1'b1;
        parallelDataIn = 8'hFF;
        tick();
        parallelLoad      = 1'b0;
        serialDataIn      = 1'b0;
        peripheralClkEdge = 1'b1;
        tick();
        tick();
        tick();
        check("mid_shift3", parallelDataOut, 8'h1F);
        reset_n = 1'b0;
        tick();
        check("mid_reset_pdo", parallelDataOut, 8'h00);
        reset_n      = 1'b1;
        serialDataIn = 1'b1;
        tick();
        peripheralClkEdge = 1'b0;
        check("post_reset_shift_pdo", parallelDataOut, 8'h80);
        check("post_reset_shift_sdo", {7'd0, serialDataOut}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
